// File: rtl/lcd_bus_if.sv
// Requester/LCD-pin bundle for lcd_bus_arbiter; i_/o_ are named from the arbiter's side.
interface lcd_bus_if;
  logic       i_req0;
  logic       i_rs0;
  logic [7:0] i_data0;
  logic       o_ack0;
  logic       i_req1;
  logic       i_rs1;
  logic [7:0] i_data1;
  logic       o_ack1;
  logic       o_busy;
  logic [1:0] o_grant;
  logic       o_lcd_e;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  modport master (
    output i_req0, i_rs0, i_data0, i_req1, i_rs1, i_data1,
    input  o_ack0, o_ack1, o_busy, o_grant, o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data
  );

  modport slave (
    input  i_req0, i_rs0, i_data0, i_req1, i_rs1, i_data1,
    output o_ack0, o_ack1, o_busy, o_grant, o_lcd_e, o_lcd_rs, o_lcd_rw, o_lcd_data
  );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin owner of a shared HD44780 8-bit bus: latches the winner's RS/byte,
// strobes E with setup/pulse/hold timing, then waits out the execution time before Ack.
module lcd_bus_arbiter #(
  parameter int unsigned SETUP_CYC     = 2,
  parameter int unsigned PULSE_CYC     = 12,
  parameter int unsigned HOLD_CYC      = 2,
  parameter int unsigned EXEC_CYC      = 2000,
  parameter int unsigned SLOW_EXEC_CYC = 82000
) (
  input  logic      i_clk,
  input  logic      i_rst,
  lcd_bus_if.slave  bus
);

  localparam int unsigned MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_B   = (HOLD_CYC > EXEC_CYC) ? HOLD_CYC : EXEC_CYC;
  localparam int unsigned MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_ALL = (MAX_C > SLOW_EXEC_CYC) ? MAX_C : SLOW_EXEC_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    EXEC  = 3'd4
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_grant;
  logic               r_last;
  logic               r_lcd_rs;
  logic [7:0]         r_lcd_data;
  logic               r_lcd_e;
  logic               r_busy;
  logic [1:0]         r_ack;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [1:0]         w_grant_nxt;
  logic               w_last_nxt;
  logic               w_rs_nxt;
  logic [7:0]         w_data_nxt;
  logic               w_pick1;
  logic [1:0]         w_ack_nxt;
  logic               w_slow;

  // Clear/home need the long execution wait.
  assign w_slow = !r_lcd_rs && (r_lcd_data inside {8'h01, 8'h02, 8'h03});

  // Next-state, counter and latch logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_rs_nxt    = r_lcd_rs;
    w_data_nxt  = r_lcd_data;
    w_pick1     = 1'b0;
    w_ack_nxt   = 2'b00;

    case (r_state)
      IDLE: begin
        if (bus.i_req0 || bus.i_req1) begin
          w_pick1     = bus.i_req1 && (!bus.i_req0 || !r_last);
          w_grant_nxt = w_pick1 ? 2'b10 : 2'b01;
          w_last_nxt  = w_pick1;
          w_rs_nxt    = w_pick1 ? bus.i_rs1 : bus.i_rs0;
          w_data_nxt  = w_pick1 ? bus.i_data1 : bus.i_data0;
          w_cnt_nxt   = CNT_W'(SETUP_CYC - 1);
          w_state_nxt = SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
          w_state_nxt = PULSE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      PULSE: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = CNT_W'(HOLD_CYC - 1);
          w_state_nxt = HOLD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = w_slow ? CNT_W'(SLOW_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
          w_state_nxt = EXEC;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      EXEC: begin
        if (r_cnt == '0) begin
          w_grant_nxt = 2'b00;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_state_nxt = IDLE;
      end
    endcase

    // Ack is registered one cycle early so it is high exactly in the EXEC cnt==0 cycle.
    if (w_state_nxt == EXEC && w_cnt_nxt == '0) begin
      w_ack_nxt = w_grant_nxt;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_grant    <= 2'b00;
      r_last     <= 1'b1;
      r_lcd_rs   <= 1'b0;
      r_lcd_data <= 8'h00;
      r_lcd_e    <= 1'b0;
      r_busy     <= 1'b0;
      r_ack      <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant    <= w_grant_nxt;
      r_last     <= w_last_nxt;
      r_lcd_rs   <= w_rs_nxt;
      r_lcd_data <= w_data_nxt;
      r_lcd_e    <= (w_state_nxt == PULSE);
      r_busy     <= (w_state_nxt != IDLE);
      r_ack      <= w_ack_nxt;
    end
  end

  assign bus.o_ack0     = r_ack[0];
  assign bus.o_ack1     = r_ack[1];
  assign bus.o_busy     = r_busy;
  assign bus.o_grant    = r_grant;
  assign bus.o_lcd_e    = r_lcd_e;
  assign bus.o_lcd_rs   = r_lcd_rs;
  assign bus.o_lcd_rw   = 1'b0;
  assign bus.o_lcd_data = r_lcd_data;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened execution waits; latencies are
// counted in falling edges after the IDLE edge that samples the request.
module tb_lcd_bus_arbiter;

  localparam int unsigned T_SETUP = 2;
  localparam int unsigned T_PULSE = 12;
  localparam int unsigned T_HOLD  = 2;
  localparam int unsigned T_EXEC  = 200;
  localparam int unsigned T_SLOW  = 1000;
  localparam int L_FAST = 216;   // 2 + 12 + 2 + 200
  localparam int L_SLOW = 1016;  // 2 + 12 + 2 + 1000

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_bus_if bus ();

  lcd_bus_arbiter #(
    .SETUP_CYC     (T_SETUP),
    .PULSE_CYC     (T_PULSE),
    .HOLD_CYC      (T_HOLD),
    .EXEC_CYC      (T_EXEC),
    .SLOW_EXEC_CYC (T_SLOW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  int         e_first;
  int         e_cnt;
  logic [1:0] e_grant;
  logic [7:0] e_data;
  logic       e_rs;

  logic [8:0] t4_vec [6] = '{9'h001, 9'h003, 9'h038, 9'h101, 9'h000, 9'h004};
  int         t4_lat [6] = '{L_SLOW, L_SLOW, L_FAST, L_FAST, L_FAST, L_FAST};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next Ack (bounded), recording the E strobe seen on the way.
  task automatic wait_ack(input int bound, output int k, output logic [1:0] who);
    k = 0; who = 2'b00;
    e_first = 0; e_cnt = 0; e_grant = 2'b00; e_data = 8'h00; e_rs = 1'b0;
    while (k < bound && who == 2'b00) begin
      @(negedge clk);
      k++;
      if (bus.o_lcd_e) begin
        if (e_cnt == 0) begin
          e_first = k; e_grant = bus.o_grant; e_data = bus.o_lcd_data; e_rs = bus.o_lcd_rs;
        end
        e_cnt++;
      end
      who = {bus.o_ack1, bus.o_ack0};
    end
  endtask

  // Drops both requests and checks the single idle cycle after an Ack.
  task automatic idle_gap();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    @(negedge clk);
    check("gap_ack", {bus.o_ack1, bus.o_ack0}, 2'b00);
    check("gap_busy", bus.o_busy, 1'b0);
    check("gap_grant", bus.o_grant, 2'b00);
  endtask

  initial begin
    int         k;
    int         n;
    logic [1:0] who;

    rst = 1'b1;
    bus.i_req0 = 1'b0; bus.i_rs0 = 1'b0; bus.i_data0 = 8'h00;
    bus.i_req1 = 1'b0; bus.i_rs1 = 1'b0; bus.i_data1 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy",  bus.o_busy, 1'b0);
    check("rst_grant", bus.o_grant, 2'b00);
    check("rst_e",     bus.o_lcd_e, 1'b0);
    check("rst_rs",    bus.o_lcd_rs, 1'b0);
    check("rst_data",  bus.o_lcd_data, 8'h00);
    check("rst_ack",   {bus.o_ack1, bus.o_ack0}, 2'b00);
    check("rst_rw",    bus.o_lcd_rw, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single data write from requester 0.
    bus.i_rs0 = 1'b1; bus.i_data0 = 8'h41; bus.i_req0 = 1'b1;
    wait_ack(3000, k, who);
    check("t1_who",     who, 2'b01);
    check("t1_lat",     k, L_FAST);
    check("t1_e_first", e_first, 3);
    check("t1_e_cnt",   e_cnt, 12);
    check("t1_grant",   e_grant, 2'b01);
    check("t1_rs",      bus.o_lcd_rs, 1'b1);
    check("t1_data",    bus.o_lcd_data, 8'h41);
    check("t1_busy",    bus.o_busy, 1'b1);
    idle_gap();
    check("t1_hold_data", bus.o_lcd_data, 8'h41);

    // Simultaneous requests after reset: requester 0 wins the first tie.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    bus.i_rs0 = 1'b1; bus.i_data0 = 8'h30; bus.i_rs1 = 1'b1; bus.i_data1 = 8'h31;
    bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
    wait_ack(3000, k, who);
    check("t2_who0",   who, 2'b01);
    check("t2_lat0",   k, L_FAST);
    check("t2_grant0", e_grant, 2'b01);
    bus.i_req0 = 1'b0;
    wait_ack(3000, k, who);
    check("t2_who1",   who, 2'b10);
    check("t2_lat1",   k, L_FAST + 1);
    check("t2_grant1", e_grant, 2'b10);
    check("t2_data1",  e_data, 8'h31);
    idle_gap();

    // Both held for four transactions: strict alternation starting with 0.
    bus.i_data0 = 8'h10; bus.i_data1 = 8'h20;
    bus.i_req0 = 1'b1; bus.i_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(3000, k, who);
      check("t3_who",  who, (i % 2 == 0) ? 2'b01 : 2'b10);
      check("t3_lat",  k, (i == 0) ? L_FAST : L_FAST + 1);
      check("t3_data", e_data, (i % 2 == 0) ? 8'h10 : 8'h20);
    end
    idle_gap();

    // Execution-time selection: only RS=0 with 01/02/03 takes the slow wait.
    for (int i = 0; i < 6; i++) begin
      bus.i_rs0 = t4_vec[i][8]; bus.i_data0 = t4_vec[i][7:0]; bus.i_req0 = 1'b1;
      wait_ack(3000, k, who);
      check("t4_who", who, 2'b01);
      check("t4_lat", k, t4_lat[i]);
      check("t4_rs",  e_rs, t4_vec[i][8]);
      idle_gap();
    end

    // Reset in the middle of the E pulse.
    bus.i_rs0 = 1'b1; bus.i_data0 = 8'h55; bus.i_req0 = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_e_pre", bus.o_lcd_e, 1'b1);
    rst = 1'b1; bus.i_req0 = 1'b0;
    @(negedge clk);
    check("t5_e",     bus.o_lcd_e, 1'b0);
    check("t5_busy",  bus.o_busy, 1'b0);
    check("t5_grant", bus.o_grant, 2'b00);
    check("t5_data",  bus.o_lcd_data, 8'h00);
    rst = 1'b0;
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.o_ack0 || bus.o_ack1) n++;
    end
    check("t5_no_ack", n, 0);
    bus.i_rs1 = 1'b1; bus.i_data1 = 8'h42; bus.i_req1 = 1'b1;
    wait_ack(3000, k, who);
    check("t5_who",   who, 2'b10);
    check("t5_lat",   k, L_FAST);
    check("t5_grant1", e_grant, 2'b10);
    check("t5_data1", e_data, 8'h42);
    idle_gap();

    // Request dropped and data changed during SETUP: latched values complete.
    bus.i_rs1 = 1'b1; bus.i_data1 = 8'h61; bus.i_req1 = 1'b1;
    @(negedge clk);
    bus.i_req1 = 1'b0; bus.i_data1 = 8'hFF;
    wait_ack(3000, k, who);
    check("t6_who",    who, 2'b10);
    check("t6_lat",    k, L_FAST - 1);
    check("t6_e_data", e_data, 8'h61);
    check("t6_data",   bus.o_lcd_data, 8'h61);
    idle_gap();
    n = 0;
    repeat (300) begin
      @(negedge clk);
      if (bus.o_ack0 || bus.o_ack1) n++;
    end
    check("t6_no_dup", n, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
